burst_mem_responder: RTL and testbench

Synthesizable responder for the 32-bit burst memory bus: the memory end of the link the cacheline adaptor drives. It accepts one read or write line request at a time and waits a fixed access latency. It then streams `BURST_LEN` consecutive 32-bit beats, each qualified by `mem_resp`, to or from an internal word-addressed RAM. It replaces the behavioural physical memory model in synthesis builds and is usable standalone on the bus in benches.

---
 rtl/burst_mem_responder.sv | 141 ++++++++++++++
 tb/tb_burst_mem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder.sv
// Memory end of the 32-bit burst bus: accepts one line request at a time,
// waits LATENCY cycles, then streams BURST_LEN beats to/from an internal
// word-addressed RAM. An issue FSM walks the beats; a one-cycle output
// stage turns each issued beat into a registered strobe/data/commit, so
// no input reaches an output combinationally.
module burst_mem_responder #(
    parameter int    ADDR_WIDTH = 13,
    parameter int    BURST_LEN  = 8,
    parameter int    LATENCY    = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic        MEM_CLK,
    input  logic        rst_n,
    input  logic [31:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        busy,
    output logic [2:0]  errcode
);

    localparam int BW = $clog2(BURST_LEN);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t                  state, state_nxt;
    logic                    run_en;      // synchronized reset release
    logic [CW-1:0]           lat_cnt;
    logic [BW-1:0]           beat;
    logic [ADDR_WIDTH-1:0]   base;
    logic                    dir_wr;
    logic                    wr_pend;     // a write beat is on the bus this cycle
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    done_q;      // post-burst turnaround cycle

    logic [31:0] ram [0:(2**ADDR_WIDTH)-1];

    logic                  accept, both_req, req_own, req_other, abort;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  unused_addr_hi;

    assign both_req   = mem_read && mem_write;
    assign accept     = run_en && (mem_read ^ mem_write);
    assign req_own    = dir_wr ? mem_write : mem_read;
    assign req_other  = dir_wr ? mem_read  : mem_write;
    // A dropped request or a flip to the other direction ends the transaction.
    assign abort      = !req_own || req_other;
    // Aligned base keeps the sum inside one line; overflow wraps to word 0.
    assign beat_addr  = base + ADDR_WIDTH'(beat);
    assign busy       = (state != IDLE) || done_q;
    assign unused_addr_hi = &{1'b0, mem_address[31:ADDR_WIDTH+2]};

    // State register.
    always_ff @(posedge MEM_CLK or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (abort) state_nxt = IDLE;
                     else if (lat_cnt == '0) state_nxt = BURST;
            BURST:   if (abort) state_nxt = IDLE;
                     else if (beat == BW'(BURST_LEN - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, latency/beat counters, error flags and output stage.
    always_ff @(posedge MEM_CLK or negedge rst_n) begin
        if (!rst_n) begin
            run_en    <= 1'b0;
            lat_cnt   <= '0;
            beat      <= '0;
            base      <= '0;
            dir_wr    <= 1'b0;
            wr_pend   <= 1'b0;
            wr_addr   <= '0;
            done_q    <= 1'b0;
            mem_resp  <= 1'b0;
            mem_rdata <= '0;
            errcode   <= '0;
        end else begin
            run_en   <= 1'b1;
            mem_resp <= 1'b0;
            wr_pend  <= 1'b0;
            done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dir_wr  <= mem_write;
                        base    <= mem_address[ADDR_WIDTH+1:2] & ~ADDR_WIDTH'(BURST_LEN - 1);
                        lat_cnt <= CW'(LATENCY - 1);
                        beat    <= '0;
                        if (mem_address[BW+1:0] != '0) errcode[2] <= 1'b1;
                    end else if (run_en && both_req) begin
                        errcode[0] <= 1'b1;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        errcode[1] <= 1'b1;
                        if (both_req) errcode[0] <= 1'b1;
                    end else if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - CW'(1);
                    end
                end
                BURST: begin
                    if (abort) begin
                        errcode[1] <= 1'b1;
                        if (both_req) errcode[0] <= 1'b1;
                    end else begin
                        mem_resp <= 1'b1;
                        beat     <= beat + BW'(1);
                        if (dir_wr) begin
                            wr_pend <= 1'b1;
                            wr_addr <= beat_addr;
                        end else begin
                            mem_rdata <= ram[beat_addr];
                        end
                    end
                end
                DONE:    done_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Commit the write beat at the edge that ends its strobe cycle.
    always_ff @(posedge MEM_CLK) begin
        if (wr_pend) ram[wr_addr] <= mem_wdata;
    end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Randomized bench for burst_mem_responder against a word-level memory model
// and cycle-exact beat timing derived from acceptance edge E0.
module tb_burst_mem_responder;

    localparam int AW    = 13;
    localparam int BL    = 8;
    localparam int LAT   = 4;
    localparam int DEPTH = 2 ** AW;

    logic        MEM_CLK = 1'b0;
    logic        rst_n   = 1'b0;
    logic [31:0] mem_address = '0;
    logic        mem_read  = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        busy;
    logic [2:0]  errcode;

    burst_mem_responder #(.ADDR_WIDTH(AW), .BURST_LEN(BL), .LATENCY(LAT)) dut (
        .MEM_CLK     (MEM_CLK),
        .rst_n       (rst_n),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .busy        (busy),
        .errcode     (errcode)
    );

    always #5 MEM_CLK = ~MEM_CLK;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] mem_m [int];     // reference RAM: word index -> data
    logic [2:0]  exp_err = '0;
    logic [31:0] wbuf [BL];
    int          pool [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic chk_rst_vals();
        chk("rst_resp",  32'(mem_resp), 32'd0);
        chk("rst_rdata", mem_rdata,     32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_err",   32'(errcode),  32'd0);
    endtask

    // Called and returns just after a negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_rst_vals();
        exp_err = '0;
        @(negedge MEM_CLK);
        rst_n = 1'b1;
        @(negedge MEM_CLK);
    endtask

    // One line transaction starting at a negedge. cut < BL interrupts at beat cut:
    // reads drop mem_read after that beat, writes hit reset during that beat.
    task automatic txn(input bit wr, input logic [31:0] addr, input int cut);
        int base, i, w;
        base = (int'((addr >> 2) % DEPTH) / BL) * BL;
        mem_address = addr;
        mem_read    = !wr;
        mem_write   = wr;
        @(posedge MEM_CLK);
        if (addr % (4 * BL) != 0) exp_err[2] = 1'b1;
        for (int k = 0; k <= LAT + BL; k++) begin
            @(negedge MEM_CLK);
            i = k - LAT - 1;
            chk("busy", 32'(busy), 32'd1);
            if (i < 0) begin
                chk("resp_wait", 32'(mem_resp), 32'd0);
                mem_wdata = $urandom;
            end else begin
                w = (base + i) % DEPTH;
                chk("resp_beat", 32'(mem_resp), 32'd1);
                if (wr) begin
                    mem_wdata = wbuf[i];
                    if (i == cut) begin
                        rst_n = 1'b0;
                        #1;
                        chk_rst_vals();
                        exp_err   = '0;
                        mem_write = 1'b0;
                        @(negedge MEM_CLK);
                        rst_n = 1'b1;
                        @(negedge MEM_CLK);
                        return;
                    end
                    mem_m[w] = wbuf[i];
                end else begin
                    if (mem_m.exists(w)) chk("rdata", mem_rdata, mem_m[w]);
                    if (i == cut) begin
                        mem_read = 1'b0;
                        @(negedge MEM_CLK);
                        chk("drop_resp", 32'(mem_resp), 32'd0);
                        chk("drop_busy", 32'(busy), 32'd0);
                        exp_err[1] = 1'b1;
                        chk("drop_err", 32'(errcode), 32'(exp_err));
                        return;
                    end
                end
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge MEM_CLK);
        chk("done_resp", 32'(mem_resp), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        chk("err", 32'(errcode), 32'(exp_err));
    endtask

    task automatic both_high();
        mem_address = $urandom;
        mem_read    = 1'b1;
        mem_write   = 1'b1;
        repeat (3) begin
            @(negedge MEM_CLK);
            chk("both_resp", 32'(mem_resp), 32'd0);
            chk("both_busy", 32'(busy), 32'd0);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        exp_err[0] = 1'b1;
        chk("both_err", 32'(errcode), 32'(exp_err));
    endtask

    task automatic fill_rand();
        for (int j = 0; j < BL; j++) wbuf[j] = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired n_pass=%0d n_chk=%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          ln, mis;
        bit          wr;

        repeat (2) @(negedge MEM_CLK);
        chk_rst_vals();
        rst_n = 1'b1;
        @(negedge MEM_CLK);

        // Preload words 0..15 and the other lines used below through the bus.
        for (int j = 0; j < BL; j++) wbuf[j] = 32'h1000 + j;
        txn(1'b1, 32'h0000_0000, BL);
        for (int j = 0; j < BL; j++) wbuf[j] = 32'h1008 + j;
        txn(1'b1, 32'h0000_0020, BL);
        pool[0] = 0;
        pool[1] = 1;
        pool[2] = DEPTH / BL - 1;
        for (int p = 3; p < 8; p++) pool[p] = $urandom_range(2, DEPTH / BL - 2);
        for (int p = 2; p < 8; p++) begin
            fill_rand();
            txn(1'b1, 32'(pool[p] * BL * 4), BL);
        end

        // RAM survives reset.
        do_reset();
        txn(1'b0, 32'h0000_0000, BL);

        // Write line 0x20 then read it back; line 0 untouched.
        for (int j = 0; j < BL; j++) wbuf[j] = 32'hA0 + j;
        txn(1'b1, 32'h0000_0020, BL);
        txn(1'b0, 32'h0000_0020, BL);
        txn(1'b0, 32'h0000_0000, BL);

        // Misaligned read serves line 0x20 and flags errcode[2].
        txn(1'b0, 32'h0000_0024, BL);
        do_reset();

        // Top line with junk high address bits, then simultaneous read/write.
        a = $urandom;
        a[AW+1:0] = '0;
        a = a | 32'((DEPTH - BL) * 4);
        txn(1'b0, a, BL);
        both_high();
        do_reset();

        // Drop after beat 3, then a clean read still completes.
        txn(1'b0, 32'h0000_0020, 3);
        txn(1'b0, 32'h0000_0020, BL);
        do_reset();

        // Randomized back-to-back traffic over the preloaded lines.
        for (int n = 0; n < 40; n++) begin
            ln  = pool[$urandom_range(0, 7)];
            mis = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4 * BL - 1) : 0;
            a = $urandom;
            a[AW+1:0] = (AW + 2)'(ln * BL * 4 + mis);
            wr = 1'($urandom_range(0, 1));
            if (wr) fill_rand();
            txn(wr, a, BL);
        end

        // Reset during write beat 5: beats 0..4 land, 5..7 keep old data.
        fill_rand();
        txn(1'b1, 32'(pool[4] * BL * 4), 5);
        txn(1'b0, 32'(pool[4] * BL * 4), BL);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
